// File: rtl/rf_pkg.sv
// Shared types and helpers for the multi-port register file.
package rf_pkg;

    typedef enum logic {RF_CLEAR, RF_RUN} rf_state_t;

    function automatic int rf_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// One registered read port: zero-register / bypass / array mux, hold on disable,
// and forced-zero output while the clear engine runs.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int BUS_WIDTH  = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clearing,
    input  logic                  en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  wr_fire,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [BUS_WIDTH-1:0]  wr_data,
    input  logic [BUS_WIDTH-1:0]  arr_data,
    output logic [BUS_WIDTH-1:0]  rd_data
);

    logic [BUS_WIDTH-1:0] mux_data;

    // wr_fire already excludes zero-register writes, so (a) can never be overridden by (b).
    always_comb begin
        mux_data = arr_data;
        if ((ZERO_REG != 0) && (addr == '0)) begin
            mux_data = '0;
        end else if ((BYPASS != 0) && wr_fire && (wr_addr == addr)) begin
            mux_data = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (clearing) begin
            rd_data <= '0;
        end else if (en) begin
            rd_data <= mux_data;
        end
    end

endmodule

// File: rtl/register_file_mp.sv
// Register file with one write port, NUM_RD registered read ports and a
// sequential clear engine that zeroes the array after reset or on request.
module register_file_mp
    import rf_pkg::*;
#(
    parameter int BUS_WIDTH  = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int NUM_RD     = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    output logic                         busy,
    input  logic                         we,
    input  logic [ADDR_WIDTH-1:0]        wr_addr,
    input  logic [BUS_WIDTH-1:0]         wr_data,
    input  logic [NUM_RD-1:0]            rd_en,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_RD*BUS_WIDTH-1:0]  rd_data
);

    localparam int N = rf_depth(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(N - 1);

    rf_state_t             state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_ptr_q, clr_ptr_d;
    logic [BUS_WIDTH-1:0]  gpr [N];
    logic                  wr_zero;
    logic                  wr_fire;
    logic                  clearing;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RF_CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // clr from either state restarts a full sweep from entry 0.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        if (clr) begin
            state_d   = RF_CLEAR;
            clr_ptr_d = '0;
        end else begin
            case (state_q)
                RF_CLEAR: begin
                    if (clr_ptr_q == LAST_PTR) begin
                        state_d   = RF_RUN;
                        clr_ptr_d = '0;
                    end else begin
                        clr_ptr_d = clr_ptr_q + ADDR_WIDTH'(1);
                    end
                end
                RF_RUN: begin
                    state_d = RF_RUN;
                end
                default: begin
                    state_d   = RF_CLEAR;
                    clr_ptr_d = '0;
                end
            endcase
        end
    end

    assign clearing = (state_q == RF_CLEAR);
    assign busy     = clearing;
    assign wr_zero  = (ZERO_REG != 0) && (wr_addr == '0);
    assign wr_fire  = (state_q == RF_RUN) && we && !clr && !wr_zero;

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clearing) begin
                gpr[clr_ptr_q] <= '0;
            end else if (wr_fire) begin
                gpr[wr_addr] <= wr_data;
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_WIDTH-1:0] port_addr;
        assign port_addr = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];

        rf_read_port #(
            .BUS_WIDTH (BUS_WIDTH),
            .ADDR_WIDTH(ADDR_WIDTH),
            .ZERO_REG  (ZERO_REG),
            .BYPASS    (BYPASS)
        ) u_port (
            .clk     (clk),
            .rst     (rst),
            .clearing(clearing),
            .en      (rd_en[i]),
            .addr    (port_addr),
            .wr_fire (wr_fire),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .arr_data(gpr[port_addr]),
            .rd_data (rd_data[i*BUS_WIDTH +: BUS_WIDTH])
        );
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp: a default instance (zero reg + bypass)
// and an alternate instance (no zero reg, no bypass) share all stimulus.
module tb_register_file_mp;

    logic       clk;
    logic       rst;
    logic       clr;
    logic       we;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic [1:0] rd_en;
    logic [5:0] rd_addr;
    logic       busy, busy_alt;
    logic [15:0] rd_data, rd_data_alt;

    int vectors;
    int miscompares;
    logic [7:0] exp_q[$];

    register_file_mp dut (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy),
        .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    register_file_mp #(.ZERO_REG(0), .BYPASS(0)) dut_alt (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy_alt),
        .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_alt)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance past one rising edge; outputs are stable and inputs may be driven.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [7:0] d);
        we = 1'b1; wr_addr = a; wr_data = d;
        step();
        we = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1; clr = 1'b0; we = 1'b0; wr_addr = '0; wr_data = '0;
        rd_en = '0; rd_addr = '0;
        step(); step(); step();
        vectors++;
        if (busy !== 1'b1 || rd_data !== 16'h0) begin
            $display("FAIL reset_state: busy=%b rd_data=%h required busy=1 rd_data=0000", busy, rd_data);
            miscompares++;
        end
        rst = 1'b0;
        rd_en = 2'b11;
        n = 0;
        while (busy === 1'b1 && n < 50) begin
            step();
            n++;
            if (busy === 1'b1) begin
                vectors++;
                if (rd_data !== 16'h0 || rd_data_alt !== 16'h0) begin
                    $display("FAIL clear_rd_zero: rd_data=%h alt=%h required 0000", rd_data, rd_data_alt);
                    miscompares++;
                end
            end
        end
        vectors++;
        if (n !== 8) begin
            $display("FAIL reset_busy_len: got %0d cycles required 8", n);
            miscompares++;
        end
        rd_en = '0;
        for (int a = 0; a < 8; a++) exp_q.push_back(8'h00);
        for (int a = 0; a < 8; a++) begin
            logic [7:0] e;
            rd_en = 2'b11; rd_addr = {3'(a), 3'(a)};
            step();
            rd_en = '0;
            e = exp_q.pop_front();
            vectors++;
            if (rd_data !== {e, e} || rd_data_alt !== {e, e}) begin
                $display("FAIL reset_contents: addr=%0d got %h alt %h required %h", a, rd_data, rd_data_alt, {e, e});
                miscompares++;
            end
        end
    endtask

    task automatic test_write_read();
        do_write(3'd3, 8'hA5);
        rd_en = 2'b11; rd_addr = {3'd3, 3'd3};
        step();
        rd_en = '0;
        vectors++;
        if (rd_data !== 16'hA5A5 || rd_data_alt !== 16'hA5A5) begin
            $display("FAIL write_read: got %h alt %h required a5a5", rd_data, rd_data_alt);
            miscompares++;
        end
    endtask

    task automatic test_bypass();
        do_write(3'd5, 8'h11);
        we = 1'b1; wr_addr = 3'd5; wr_data = 8'h22;
        rd_en = 2'b01; rd_addr = {3'd0, 3'd5};
        step();
        we = 1'b0; rd_en = '0;
        vectors++;
        if (rd_data[7:0] !== 8'h22 || rd_data_alt[7:0] !== 8'h11) begin
            $display("FAIL bypass_same_cycle: got %h alt %h required 22 / 11", rd_data[7:0], rd_data_alt[7:0]);
            miscompares++;
        end
        rd_en = 2'b01;
        step();
        rd_en = '0;
        vectors++;
        if (rd_data[7:0] !== 8'h22 || rd_data_alt[7:0] !== 8'h22) begin
            $display("FAIL bypass_later: got %h alt %h required 22 / 22", rd_data[7:0], rd_data_alt[7:0]);
            miscompares++;
        end
    endtask

    task automatic test_zero_reg();
        we = 1'b1; wr_addr = 3'd0; wr_data = 8'hFF;
        rd_en = 2'b01; rd_addr = {3'd0, 3'd0};
        step();
        we = 1'b0;
        vectors++;
        if (rd_data[7:0] !== 8'h00 || rd_data_alt[7:0] !== 8'h00) begin
            $display("FAIL zero_same_cycle: got %h alt %h required 00 / 00", rd_data[7:0], rd_data_alt[7:0]);
            miscompares++;
        end
        step();
        rd_en = '0;
        vectors++;
        if (rd_data[7:0] !== 8'h00 || rd_data_alt[7:0] !== 8'hFF) begin
            $display("FAIL zero_after: got %h alt %h required 00 / ff", rd_data[7:0], rd_data_alt[7:0]);
            miscompares++;
        end
    endtask

    task automatic test_hold();
        do_write(3'd4, 8'h3C);
        rd_en = 2'b10; rd_addr = {3'd4, 3'd0};
        step();
        rd_en = '0;
        vectors++;
        if (rd_data[15:8] !== 8'h3C) begin
            $display("FAIL hold_load: got %h required 3c", rd_data[15:8]);
            miscompares++;
        end
        for (int k = 0; k < 4; k++) begin
            rd_addr = {3'(k + 1), 3'(k)};
            we = 1'b1; wr_addr = 3'd4; wr_data = 8'h70 + 8'(k);
            step();
            we = 1'b0;
            vectors++;
            if (rd_data[15:8] !== 8'h3C || rd_data_alt[15:8] !== 8'h3C) begin
                $display("FAIL hold_stable: step %0d got %h alt %h required 3c", k, rd_data[15:8], rd_data_alt[15:8]);
                miscompares++;
            end
        end
    endtask

    task automatic test_clr_mid();
        int n;
        for (int a = 1; a < 8; a++) do_write(3'(a), 8'(a));
        clr = 1'b1; we = 1'b1; wr_addr = 3'd2; wr_data = 8'h99;
        rd_en = 2'b01; rd_addr = {3'd0, 3'd2};
        step();
        clr = 1'b0; we = 1'b0; rd_en = '0;
        vectors++;
        if (busy !== 1'b1 || rd_data[7:0] !== 8'h02) begin
            $display("FAIL clr_entry: busy=%b rd=%h required busy=1 rd=02", busy, rd_data[7:0]);
            miscompares++;
        end
        n = 0;
        while (busy === 1'b1 && n < 50) begin
            step();
            n++;
            clr = (n == 2);
            if (busy === 1'b1) begin
                vectors++;
                if (rd_data !== 16'h0) begin
                    $display("FAIL clr_rd_zero: got %h required 0000", rd_data);
                    miscompares++;
                end
            end
        end
        clr = 1'b0;
        vectors++;
        if (n !== 11) begin
            $display("FAIL clr_busy_len: got %0d cycles required 11", n);
            miscompares++;
        end
        for (int a = 0; a < 8; a++) exp_q.push_back(8'h00);
        for (int a = 0; a < 8; a++) begin
            logic [7:0] e;
            rd_en = 2'b11; rd_addr = {3'(a), 3'(a)};
            step();
            rd_en = '0;
            e = exp_q.pop_front();
            vectors++;
            if (rd_data !== {e, e} || rd_data_alt !== {e, e}) begin
                $display("FAIL clr_contents: addr=%0d got %h alt %h required %h", a, rd_data, rd_data_alt, {e, e});
                miscompares++;
            end
        end
    endtask

    task automatic test_rst_during_clear();
        int n;
        do_write(3'd6, 8'h5A);
        clr = 1'b1;
        step();
        clr = 1'b0;
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 50) begin
            step();
            n++;
        end
        vectors++;
        if (n !== 8) begin
            $display("FAIL rst_in_clear_len: got %0d cycles required 8", n);
            miscompares++;
        end
        rd_en = 2'b11; rd_addr = {3'd6, 3'd6};
        step();
        rd_en = '0;
        vectors++;
        if (rd_data !== 16'h0 || rd_data_alt !== 16'h0) begin
            $display("FAIL rst_in_clear_data: got %h alt %h required 0000", rd_data, rd_data_alt);
            miscompares++;
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_write_read();
        test_bypass();
        test_zero_reg();
        test_hold();
        test_clr_mid();
        test_rst_during_clear();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
